// File: rtl/xbar_switch_alloc_if.sv
// ---------------------------------------------------------------------------
// xbar_switch_alloc_if
// Request/grant bundle between the input VC buffers, the switch allocator
// and the crossbar.
//   req_valid      input i presents a flit
//   req_dst        destination output of input i, slice [i*OUT_W +: OUT_W]
//   req_tail       presented flit is a tail (single-flit packet = head+tail)
//   out_ready      output j has credit this cycle
//   xpoints_enable bit i*N_OUT+j closes crosspoint input i -> output j
//   in_grant       flit from input i transfers this cycle (buffer pops it)
//   out_valid      output j carries a valid flit this cycle
// Modports: master = buffer/credit side, slave = allocator.
// ---------------------------------------------------------------------------
interface xbar_switch_alloc_if #(
    parameter int M_IN  = 28,
    parameter int N_OUT = 7,
    parameter int OUT_W = 3
);
    logic [M_IN-1:0]       req_valid;
    logic [M_IN*OUT_W-1:0] req_dst;
    logic [M_IN-1:0]       req_tail;
    logic [N_OUT-1:0]      out_ready;
    logic [M_IN*N_OUT-1:0] xpoints_enable;
    logic [M_IN-1:0]       in_grant;
    logic [N_OUT-1:0]      out_valid;

    modport master (
        output req_valid, req_dst, req_tail, out_ready,
        input  xpoints_enable, in_grant, out_valid
    );

    modport slave (
        input  req_valid, req_dst, req_tail, out_ready,
        output xpoints_enable, in_grant, out_valid
    );
endinterface

// File: rtl/xbar_switch_alloc.sv
// ---------------------------------------------------------------------------
// xbar_switch_alloc
// Wormhole switch allocator for an M_IN x N_OUT crossbar. Each output runs a
// round-robin arbiter over the inputs that target it; the winner owns the
// output from its head flit through its tail flit.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    xbar_switch_alloc_if.slave (requests in; crosspoints/grants out)
// Optional feature (macro XBAR_ALLOC_TIMEOUT_EN): per-output watchdog that
// releases a lock after TIMEOUT_CYC consecutive cycles with the owner idle.
// ---------------------------------------------------------------------------
module xbar_switch_alloc #(
    parameter int M_IN        = 28,
    parameter int N_OUT       = 7,
    parameter int OUT_W       = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    xbar_switch_alloc_if.slave  bus
);

    localparam int IDX_W = (M_IN > 1) ? $clog2(M_IN) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_t;

    out_state_t            state_r     [N_OUT];
    out_state_t            state_nxt_s [N_OUT];
    logic [IDX_W-1:0]      owner_r     [N_OUT];
    logic [IDX_W-1:0]      owner_nxt_s [N_OUT];
    logic [IDX_W-1:0]      ptr_r       [N_OUT];
    logic [IDX_W-1:0]      ptr_nxt_s   [N_OUT];
    logic [IDX_W:0]        pick_s      [N_OUT];
    logic [M_IN-1:0]       req_set_s   [N_OUT];
    logic [M_IN-1:0]       busy_s;
    logic [M_IN-1:0]       in_grant_s;
    logic [N_OUT-1:0]      transfer_s;
    logic [N_OUT-1:0]      tail_done_s;
    logic [N_OUT-1:0]      timeout_s;
    logic [M_IN*N_OUT-1:0] xpoints_r;
    logic [M_IN*N_OUT-1:0] xpoints_nxt_s;

    // Cyclic first-set search starting at ptr; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [M_IN-1:0]  req,
                                               input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] sel;
        logic [IDX_W:0]   idx;
        found = 1'b0;
        sel   = {IDX_W{1'b0}};
        for (int k = 0; k < M_IN; k++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(M_IN)) begin
                idx = idx - (IDX_W+1)'(M_IN);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // (v + 1) mod M_IN for round-robin pointer advance.
    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(M_IN-1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return v + IDX_W'(1);
        end
    endfunction

    // Inputs already owning an output may not win another one.
    always_comb begin
        busy_s = {M_IN{1'b0}};
        for (int j = 0; j < N_OUT; j++) begin
            busy_s[owner_r[j]] = busy_s[owner_r[j]] | (state_r[j] == ST_LOCKED);
        end
    end

    // Per-output request sets; a destination >= N_OUT matches no output.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < M_IN; i++) begin
                req_set_s[j][i] = bus.req_valid[i] & ~busy_s[i] &
                                  (bus.req_dst[i*OUT_W +: OUT_W] == OUT_W'(j));
            end
            pick_s[j] = rr_pick(req_set_s[j], ptr_r[j]);
        end
    end

    // Transfers on locked outputs and the resulting per-input pop strobes.
    always_comb begin
        in_grant_s = {M_IN{1'b0}};
        for (int j = 0; j < N_OUT; j++) begin
            transfer_s[j]  = (state_r[j] == ST_LOCKED) & bus.req_valid[owner_r[j]] &
                             bus.out_ready[j];
            tail_done_s[j] = transfer_s[j] & bus.req_tail[owner_r[j]];
            in_grant_s[owner_r[j]] = in_grant_s[owner_r[j]] | transfer_s[j];
        end
    end

`ifdef XBAR_ALLOC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt_r [N_OUT];

    // Watchdog fires on the TIMEOUT_CYC-th consecutive owner-idle cycle.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            timeout_s[j] = (state_r[j] == ST_LOCKED) & ~bus.req_valid[owner_r[j]] &
                           (idle_cnt_r[j] == TO_W'(TIMEOUT_CYC - 1));
        end
    end

    // Count owner-idle cycles; any valid cycle, release or new lock restarts it.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_OUT; j++) begin
            if (!rst_n) begin
                idle_cnt_r[j] <= {TO_W{1'b0}};
            end else if ((state_r[j] == ST_LOCKED) && !tail_done_s[j] && !timeout_s[j] &&
                         !bus.req_valid[owner_r[j]]) begin
                idle_cnt_r[j] <= idle_cnt_r[j] + TO_W'(1);
            end else begin
                idle_cnt_r[j] <= {TO_W{1'b0}};
            end
        end
    end
`else
    assign timeout_s = {N_OUT{1'b0}};
`endif

    // Per-output next state: arbitrate when idle or when the tail leaves.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            state_nxt_s[j] = state_r[j];
            owner_nxt_s[j] = owner_r[j];
            ptr_nxt_s[j]   = ptr_r[j];
            case (state_r[j])
                ST_IDLE: begin
                    if (pick_s[j][IDX_W]) begin
                        state_nxt_s[j] = ST_LOCKED;
                        owner_nxt_s[j] = pick_s[j][IDX_W-1:0];
                        ptr_nxt_s[j]   = inc_wrap(pick_s[j][IDX_W-1:0]);
                    end else begin
                        state_nxt_s[j] = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (tail_done_s[j]) begin
                        // Back-to-back handover; the departing owner is busy
                        // this cycle and so cannot re-win immediately.
                        if (pick_s[j][IDX_W]) begin
                            state_nxt_s[j] = ST_LOCKED;
                            owner_nxt_s[j] = pick_s[j][IDX_W-1:0];
                            ptr_nxt_s[j]   = inc_wrap(pick_s[j][IDX_W-1:0]);
                        end else begin
                            state_nxt_s[j] = ST_IDLE;
                        end
                    end else if (timeout_s[j]) begin
                        state_nxt_s[j] = ST_IDLE;
                        ptr_nxt_s[j]   = inc_wrap(owner_r[j]);
                    end else begin
                        state_nxt_s[j] = ST_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s[j] = ST_IDLE;
                end
            endcase
        end
    end

    // Crosspoint map for the next cycle, so the enables come straight from flops.
    always_comb begin
        xpoints_nxt_s = {(M_IN*N_OUT){1'b0}};
        for (int j = 0; j < N_OUT; j++) begin
            xpoints_nxt_s[int'(owner_nxt_s[j])*N_OUT + j] =
                xpoints_nxt_s[int'(owner_nxt_s[j])*N_OUT + j] | (state_nxt_s[j] == ST_LOCKED);
        end
    end

    // State, owner, pointer and crosspoint registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                state_r[j] <= ST_IDLE;
                owner_r[j] <= {IDX_W{1'b0}};
                ptr_r[j]   <= {IDX_W{1'b0}};
            end
            xpoints_r <= {(M_IN*N_OUT){1'b0}};
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                state_r[j] <= state_nxt_s[j];
                owner_r[j] <= owner_nxt_s[j];
                ptr_r[j]   <= ptr_nxt_s[j];
            end
            xpoints_r <= xpoints_nxt_s;
        end
    end

    assign bus.xpoints_enable = xpoints_r;
    assign bus.in_grant       = in_grant_s;
    assign bus.out_valid      = transfer_s;

endmodule
